ariane_regfile_lvt: RTL and testbench

- Next-generation FPGA register file built from a live-value-table (LVT).
- One distributed-RAM bank per write port, each with NR_READ_PORTS async read ports; a per-word LVT selects which bank holds the live value.
- Adds over the previous generation: parametrised depth, optional same-cycle write-to-read bypass, a hardware sweep-clear FSM (after reset and on flush), and a registered write-collision flag.
- Sits in the issue/commit path as the integer or FP register file.

---
 rtl/ariane_regfile_lvt.sv | 170 +++++++++++++++++
 tb/tb_ariane_regfile_lvt.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ariane_regfile_lvt.sv
// Live-value-table register file: one write bank per write port, a per-word LVT
// recording which bank holds the live value, hardware sweep-clear after reset
// and on flush, optional write-to-read bypass and a registered collision flag.
module ariane_regfile_lvt #(
   parameter int unsigned DATA_WIDTH     = 64,
   parameter int unsigned ADDR_WIDTH     = 5,
   parameter int unsigned NR_READ_PORTS  = 2,
   parameter int unsigned NR_WRITE_PORTS = 2,
   parameter bit          ZERO_REG_ZERO  = 1'b0,
   parameter bit          WRITE_BYPASS   = 1'b0
) (
   input  logic                                   clk_i,
   input  logic                                   rst_i,
   input  logic                                   flush_i,
   output logic                                   ready_o,
   input  logic [NR_READ_PORTS*ADDR_WIDTH-1:0]    raddr_i,
   output logic [NR_READ_PORTS*DATA_WIDTH-1:0]    rdata_o,
   input  logic [NR_WRITE_PORTS*ADDR_WIDTH-1:0]   waddr_i,
   input  logic [NR_WRITE_PORTS*DATA_WIDTH-1:0]   wdata_i,
   input  logic [NR_WRITE_PORTS-1:0]              we_i,
   output logic                                   collision_o
);

   localparam int unsigned NUM_WORDS = 2 ** ADDR_WIDTH;
   localparam int unsigned LVT_WIDTH = (NR_WRITE_PORTS > 1) ? $clog2(NR_WRITE_PORTS) : 1;

   typedef enum logic [0:0] {StClear, StReady} state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   clr_q, clr_d;
   logic                    collision_q, collision_d;

   logic [DATA_WIDTH-1:0]   mem [NR_WRITE_PORTS][NUM_WORDS];
   logic [LVT_WIDTH-1:0]    lvt [NUM_WORDS];

   logic [ADDR_WIDTH-1:0]   waddr [NR_WRITE_PORTS];
   logic [DATA_WIDTH-1:0]   wdata [NR_WRITE_PORTS];
   logic [ADDR_WIDTH-1:0]   raddr [NR_READ_PORTS];
   logic [NR_WRITE_PORTS-1:0] wr_en;

   logic [NR_WRITE_PORTS-1:0] bank_we;
   logic [ADDR_WIDTH-1:0]   bank_waddr [NR_WRITE_PORTS];
   logic [DATA_WIDTH-1:0]   bank_wdata [NR_WRITE_PORTS];

   // Unpack flat ports and qualify write enables (READY only, zero register dropped).
   always_comb begin
      for (int k = 0; k < NR_READ_PORTS; k++) begin
         raddr[k] = raddr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
      end
      for (int j = 0; j < NR_WRITE_PORTS; j++) begin
         waddr[j] = waddr_i[j*ADDR_WIDTH +: ADDR_WIDTH];
         wdata[j] = wdata_i[j*DATA_WIDTH +: DATA_WIDTH];
         wr_en[j] = we_i[j] && (state_q == StReady) && !rst_i &&
                    !(ZERO_REG_ZERO && (waddr[j] == '0));
      end
   end

   // Bank write ports; during the sweep bank 0 is taken over by the clear counter.
   always_comb begin
      for (int j = 0; j < NR_WRITE_PORTS; j++) begin
         bank_we[j]    = wr_en[j];
         bank_waddr[j] = waddr[j];
         bank_wdata[j] = wdata[j];
      end
      if (state_q == StClear) begin
         bank_we[0]    = 1'b1;
         bank_waddr[0] = clr_q;
         bank_wdata[0] = '0;
      end
   end

   // Distributed-RAM banks, no reset: the sweep provides the defined contents.
   always_ff @(posedge clk_i) begin
      for (int b = 0; b < NR_WRITE_PORTS; b++) begin
         if (bank_we[b]) begin
            mem[b][bank_waddr[b]] <= bank_wdata[b];
         end
      end
   end

   // LVT update; ascending loop so the highest-index port wins on a shared address.
   always_ff @(posedge clk_i) begin
      if (state_q == StClear) begin
         lvt[clr_q] <= '0;
      end else begin
         for (int j = 0; j < NR_WRITE_PORTS; j++) begin
            if (wr_en[j]) begin
               lvt[waddr[j]] <= LVT_WIDTH'(j);
            end
         end
      end
   end

   // Sweep/ready FSM next state and collision detection.
   always_comb begin
      state_d     = state_q;
      clr_d       = clr_q;
      collision_d = 1'b0;
      unique case (state_q)
         StClear: begin
            clr_d = clr_q + 1'b1;
            if (clr_q == '1) begin
               state_d = StReady;
            end
         end
         StReady: begin
            if (flush_i) begin
               state_d = StClear;
               clr_d   = '0;
            end
         end
         default: begin
            state_d = StClear;
            clr_d   = '0;
         end
      endcase
      // Flag only when the next cycle is READY, so the flag never shows during a sweep.
      if ((state_q == StReady) && !flush_i) begin
         for (int i = 0; i < NR_WRITE_PORTS; i++) begin
            for (int j = i + 1; j < NR_WRITE_PORTS; j++) begin
               if (we_i[i] && we_i[j] && (waddr[i] == waddr[j]) &&
                   (!ZERO_REG_ZERO || (waddr[i] != '0))) begin
                  collision_d = 1'b1;
               end
            end
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StClear;
         clr_q       <= '0;
         collision_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         clr_q       <= clr_d;
         collision_q <= collision_d;
      end
   end

   // Asynchronous read through the LVT, with optional same-cycle bypass.
   always_comb begin
      rdata_o = '0;
      for (int k = 0; k < NR_READ_PORTS; k++) begin
         logic [DATA_WIDTH-1:0] val;
         val = '0;
         if ((state_q == StReady) && !(ZERO_REG_ZERO && (raddr[k] == '0))) begin
            for (int b = 0; b < NR_WRITE_PORTS; b++) begin
               if (lvt[raddr[k]] == LVT_WIDTH'(b)) begin
                  val = mem[b][raddr[k]];
               end
            end
            if (WRITE_BYPASS) begin
               for (int j = 0; j < NR_WRITE_PORTS; j++) begin
                  if (wr_en[j] && (waddr[j] == raddr[k])) begin
                     val = wdata[j];
                  end
               end
            end
         end
         rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = val;
      end
   end

   assign ready_o     = (state_q == StReady);
   assign collision_o = collision_q;

endmodule

// File: tb/tb_ariane_regfile_lvt.sv
// Directed bench: instance "dut" uses default parameters, "dut_b" enables
// ZERO_REG_ZERO and WRITE_BYPASS; both see identical stimulus.
module tb_ariane_regfile_lvt;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic [9:0]    raddr;
   logic [9:0]    waddr;
   logic [127:0]  wdata;
   logic [1:0]    we;
   logic          ready_a, coll_a, ready_b, coll_b;
   logic [127:0]  rdata_a, rdata_b;

   int n_asserts = 0;
   int n_fail    = 0;

   always #5 clk = ~clk;

   ariane_regfile_lvt dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .flush_i     (flush),
      .ready_o     (ready_a),
      .raddr_i     (raddr),
      .rdata_o     (rdata_a),
      .waddr_i     (waddr),
      .wdata_i     (wdata),
      .we_i        (we),
      .collision_o (coll_a)
   );

   ariane_regfile_lvt #(
      .ZERO_REG_ZERO (1'b1),
      .WRITE_BYPASS  (1'b1)
   ) dut_b (
      .clk_i       (clk),
      .rst_i       (rst),
      .flush_i     (flush),
      .ready_o     (ready_b),
      .raddr_i     (raddr),
      .rdata_o     (rdata_b),
      .waddr_i     (waddr),
      .wdata_i     (wdata),
      .we_i        (we),
      .collision_o (coll_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input int p, input logic [4:0] a, input logic [63:0] d);
      we[p]             = 1'b1;
      waddr[p*5 +: 5]   = a;
      wdata[p*64 +: 64] = d;
   endtask

   task automatic rd(input int k, input logic [4:0] a);
      raddr[k*5 +: 5] = a;
   endtask

   function automatic logic [63:0] ra(input int k);
      return rdata_a[k*64 +: 64];
   endfunction

   function automatic logic [63:0] rb(input int k);
      return rdata_b[k*64 +: 64];
   endfunction

   initial begin
      rst = 1'b1; flush = 1'b0; raddr = '0; waddr = '0; wdata = '0; we = '0;
      tick(); tick();
      chk("reset_ready", 64'(ready_a), 64'd0);
      chk("reset_coll", 64'(coll_a), 64'd0);

      // Reset release: ready after exactly 32 edges; write during sweep ignored.
      rst = 1'b0;
      for (int i = 1; i <= 32; i++) begin
         if (i == 5) wr(0, 5'd3, 64'hAA);
         if (i == 6) we = '0;
         tick();
         chk($sformatf("clr_ready_%0d", i), 64'(ready_a), 64'(i == 32));
         chk($sformatf("clr_ready_b_%0d", i), 64'(ready_b), 64'(i == 32));
         if (i == 10) begin
            rd(0, 5'd3);
            chk("clr_rdata_zero", ra(0), 64'd0);
         end
      end
      rd(0, 5'd3); rd(1, 5'd17); #1;
      chk("post_clr_addr3", ra(0), 64'd0);
      chk("post_clr_addr17", ra(1), 64'd0);
      chk("post_clr_coll", 64'(coll_a), 64'd0);

      // Port0 then port1 write addr 5.
      wr(0, 5'd5, 64'h1111); rd(0, 5'd5);
      tick();
      we = '0; wr(1, 5'd5, 64'h2222); #1;
      chk("a5_old_nobyp", ra(0), 64'h1111);
      chk("a5_byp", rb(0), 64'h2222);
      tick();
      we = '0; #1;
      chk("a5_new", ra(0), 64'h2222);

      // Port1 alone writes addr 7, read on both ports.
      wr(1, 5'd7, 64'h33); rd(0, 5'd7); rd(1, 5'd7); #1;
      chk("a7_before", ra(0), 64'd0);
      tick();
      we = '0; #1;
      chk("a7_rd0", ra(0), 64'h33);
      chk("a7_rd1", ra(1), 64'h33);

      // Both ports hit addr 9: port 1 wins, one-cycle collision pulse.
      wr(0, 5'd9, 64'hA0); wr(1, 5'd9, 64'hB1); rd(0, 5'd9); #1;
      chk("a9_byp_hi", rb(0), 64'hB1);
      chk("a9_coll_pre", 64'(coll_a), 64'd0);
      tick();
      we = '0; #1;
      chk("a9_rd", ra(0), 64'hB1);
      chk("a9_coll", 64'(coll_a), 64'd1);
      chk("a9_coll_b", 64'(coll_b), 64'd1);
      tick();
      chk("a9_coll_drop", 64'(coll_a), 64'd0);

      // Bypass vs no bypass on addr 4.
      wr(0, 5'd4, 64'h1234); rd(0, 5'd4);
      tick();
      we = '0; wr(0, 5'd4, 64'hCAFE); #1;
      chk("a4_old", ra(0), 64'h1234);
      chk("a4_byp", rb(0), 64'hCAFE);
      tick();
      we = '0; #1;
      chk("a4_new", ra(0), 64'hCAFE);

      // Address 0 written by both ports.
      wr(0, 5'd0, 64'hFF); wr(1, 5'd0, 64'hFF); rd(0, 5'd0); #1;
      chk("z0_byp_forced", rb(0), 64'd0);
      tick();
      we = '0; #1;
      chk("z0_rd_b", rb(0), 64'd0);
      chk("z0_coll_b", 64'(coll_b), 64'd0);
      chk("z0_rd_a", ra(0), 64'hFF);
      chk("z0_coll_a", 64'(coll_a), 64'd1);

      // Fill all words, then flush.
      for (int c = 0; c < 16; c++) begin
         wr(0, 5'(c), 64'h100 + 64'(c));
         wr(1, 5'(c + 16), 64'h110 + 64'(c));
         tick();
      end
      we = '0; rd(0, 5'd20); rd(1, 5'd0); #1;
      chk("fill_a20", ra(0), 64'h114);
      chk("fill_a0", ra(1), 64'h100);
      chk("fill_b0", rb(1), 64'd0);
      chk("fill_b20", rb(0), 64'h114);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_ready_fall", 64'(ready_a), 64'd0);
      for (int i = 1; i <= 32; i++) begin
         tick();
         chk($sformatf("flush_ready_%0d", i), 64'(ready_a), 64'(i == 32));
      end
      for (int a = 0; a < 16; a++) begin
         rd(0, 5'(a)); rd(1, 5'(a + 16)); #1;
         chk($sformatf("flushed_%0d", a), ra(0), 64'd0);
         chk($sformatf("flushed_%0d", a + 16), ra(1), 64'd0);
      end

      // Reset mid-sweep at clr_q = 10 restarts it; flush during sweep ignored.
      flush = 1'b1;
      tick();
      flush = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_mid_ready", 64'(ready_a), 64'd0);
      for (int i = 1; i <= 32; i++) begin
         flush = (i == 20);
         tick();
         chk($sformatf("rst_ready_%0d", i), 64'(ready_a), 64'(i == 32));
      end
      flush = 1'b0;
      tick();
      chk("final_ready", 64'(ready_a), 64'd1);
      chk("final_coll", 64'(coll_a), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
